lrelu_beats_sender: RTL and testbench

Transmit-side counterpart of the LReLU configuration-beat counter. On `start`, it reads configuration words from a local config RAM and emits them as a valid/ready beat stream toward the LReLU engine. Beats follow the order the engine's receiving counter expects: D register, then BRAM_A, then BRAM_B swept over `clr_i`/`mtb`/`w_addr`. Each beat carries position tags, and the stream repeats for `n_groups` groups.

---
 rtl/lrelu_beats_pkg.sv | 31 +++
 rtl/lrelu_beats_skid.sv | 46 ++++
 rtl/lrelu_beats_sender.sv | 212 +++++++++++++++++++++
 tb/tb_lrelu_beats_sender.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lrelu_beats_pkg.sv
// Shared types and beat-count helpers for the LReLU config-beat sender and its receiving counter.
package lrelu_beats_pkg;

  typedef enum logic [1:0] {
    S_REG_D  = 2'd1,
    S_BRAM_A = 2'd2,
    S_BRAM_B = 2'd3
  } w_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int KW_MAX_DEF = 11;

  function automatic int calc_beats_b(input int c, input int k);
    return (k + c + 2) / 2;
  endfunction

  // Widest BRAM_B sweep occurs at clr_i == kw2 == KW_MAX/2.
  function automatic int calc_beats_max(input int kw_max);
    return calc_beats_b(kw_max / 2, kw_max / 2);
  endfunction

  localparam int BITS_KW2_DEF    = $clog2(KW_MAX_DEF / 2 + 1);
  localparam int BITS_MTB_DEF    = $clog2(KW_MAX_DEF);
  localparam int BITS_W_ADDR_DEF = $clog2(calc_beats_max(KW_MAX_DEF));

endpackage

// File: rtl/lrelu_beats_skid.sv
// Two-entry valid/ready FIFO; an empty FIFO passes the input straight through to the output.
module lrelu_beats_skid #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_empty;
  logic         w_pop;
  logic         w_store;

  assign w_empty = (r_count == 2'd0);
  assign w_pop   = i_ready & ~w_empty;
  // Store unless the beat bypasses an empty FIFO and is taken this cycle.
  assign w_store = i_valid & ~(w_empty & i_ready);
  assign o_valid = ~w_empty | i_valid;
  assign o_data  = ~w_empty ? r_mem[r_rd_ptr] : (i_valid ? i_data : '0);
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_store) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_store} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/lrelu_beats_sender.sv
// Reads LReLU config words from a local RAM and streams them as tagged beats (D, BRAM_A, BRAM_B).
// Define LRELU_SENDER_TAGS_EN to carry per-beat position tags; otherwise tag ports are tied to 0.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_ISSUE | RAM reads still to issue
// ST_DRAIN | all reads issued, waiting for the last beat handshake
module lrelu_beats_sender
  import lrelu_beats_pkg::*;
#(
  parameter int  MEMBERS     = 8,
  parameter int  WORD_W      = 16,
  parameter int  DATA_W      = MEMBERS * WORD_W,
  parameter int  KW_MAX      = KW_MAX_DEF,
  parameter int  BITS_KW2    = $clog2(KW_MAX / 2 + 1),
  parameter int  ADDR_W      = 16,
  parameter int  GRP_W       = 16,
  localparam int BITS_MTB    = $clog2(KW_MAX),
  localparam int BITS_W_ADDR = $clog2(calc_beats_max(KW_MAX))
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [BITS_KW2-1:0]    i_kw2,
  input  logic [GRP_W-1:0]       i_n_groups,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_rd_en,
  output logic [ADDR_W-1:0]      o_rd_addr,
  input  logic [DATA_W-1:0]      i_rd_data,
  output logic                   o_m_valid,
  input  logic                   i_m_ready,
  output logic [DATA_W-1:0]      o_m_data,
  output logic                   o_m_last,
  output logic [1:0]             o_m_w_sel,
  output logic [BITS_KW2-1:0]    o_m_clr_i,
  output logic [BITS_MTB-1:0]    o_m_mtb,
  output logic [BITS_W_ADDR-1:0] o_m_w_addr
);

`ifdef LRELU_SENDER_TAGS_EN
  localparam int PAY_W = 1 + 2 + BITS_KW2 + BITS_MTB + BITS_W_ADDR + DATA_W;
`else
  localparam int PAY_W = 1 + DATA_W;
`endif
  localparam logic [BITS_KW2-1:0] KW2_MAX = BITS_KW2'(KW_MAX / 2);

  state_e                 r_state, w_next;
  w_sel_e                 r_w_sel;
  logic [BITS_KW2-1:0]    r_kw2, r_clr_i, w_kw2_in;
  logic [BITS_MTB-1:0]    r_mtb;
  logic [BITS_W_ADDR-1:0] r_w_addr, w_beats_m1;
  logic [GRP_W-1:0]       r_grp, r_grp_last, w_grp_last_in;
  logic [ADDR_W-1:0]      r_rd_addr;
  logic                   r_inflight, r_p_last, r_done;
  logic                   w_accept, w_rd_en, w_last_hs;
  logic                   w_a_last, w_addr_last, w_mtb_last, w_clr_last, w_grp_end, w_stream_end;
  logic [1:0]             w_count;
  logic [PAY_W-1:0]       w_push, w_pop;

  assign w_kw2_in      = (i_kw2 > KW2_MAX) ? KW2_MAX : i_kw2;
  assign w_grp_last_in = (i_n_groups == '0) ? '0 : i_n_groups - GRP_W'(1);
  assign w_accept      = (r_state == ST_IDLE) & i_start;
  // At most two beats may be buffered or in flight, so the skid FIFO can never overflow.
  assign w_rd_en       = (r_state == ST_ISSUE) &
                         (({1'b0, w_count} + {2'b00, r_inflight}) < 3'd2);

  assign w_beats_m1   = BITS_W_ADDR'(calc_beats_b(int'(r_clr_i), int'(r_kw2)) - 1);
  assign w_a_last     = (r_w_addr == BITS_W_ADDR'(r_kw2));
  assign w_addr_last  = (r_w_addr == w_beats_m1);
  assign w_mtb_last   = (r_mtb == BITS_MTB'({r_clr_i, 1'b0}));
  assign w_clr_last   = (r_clr_i == r_kw2);
  assign w_grp_end    = (r_w_sel == S_BRAM_B) & w_addr_last & w_mtb_last & w_clr_last;
  assign w_stream_end = w_grp_end & (r_grp == r_grp_last);
  assign w_last_hs    = o_m_valid & i_m_ready & o_m_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_ISSUE;
      ST_ISSUE: if (w_rd_en && w_stream_end) w_next = ST_DRAIN;
      ST_DRAIN: if (w_last_hs) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_kw2      <= '0;
      r_grp_last <= '0;
      r_w_sel    <= S_REG_D;
      r_clr_i    <= '0;
      r_mtb      <= '0;
      r_w_addr   <= '0;
      r_grp      <= '0;
      r_rd_addr  <= '0;
    end else if (w_accept) begin
      r_kw2      <= w_kw2_in;
      r_grp_last <= w_grp_last_in;
      r_w_sel    <= S_REG_D;
      r_clr_i    <= '0;
      r_mtb      <= '0;
      r_w_addr   <= '0;
      r_grp      <= '0;
      r_rd_addr  <= '0;
    end else if (w_rd_en) begin
      r_rd_addr <= r_rd_addr + ADDR_W'(1);
      case (r_w_sel)
        S_REG_D: begin
          r_w_sel  <= S_BRAM_A;
          r_w_addr <= '0;
        end
        S_BRAM_A: begin
          if (w_a_last) begin
            r_w_sel  <= S_BRAM_B;
            r_w_addr <= '0;
            r_clr_i  <= '0;
            r_mtb    <= '0;
          end else begin
            r_w_addr <= r_w_addr + BITS_W_ADDR'(1);
          end
        end
        S_BRAM_B: begin
          if (!w_addr_last) begin
            r_w_addr <= r_w_addr + BITS_W_ADDR'(1);
          end else begin
            r_w_addr <= '0;
            if (!w_mtb_last) begin
              r_mtb <= r_mtb + BITS_MTB'(1);
            end else begin
              r_mtb <= '0;
              if (!w_clr_last) begin
                r_clr_i <= r_clr_i + BITS_KW2'(1);
              end else begin
                r_clr_i <= '0;
                r_w_sel <= S_REG_D;
                r_grp   <= r_grp + GRP_W'(1);
              end
            end
          end
        end
        default: r_w_sel <= S_REG_D;
      endcase
    end
  end

`ifdef LRELU_SENDER_TAGS_EN
  logic [1:0]             r_p_w_sel;
  logic [BITS_KW2-1:0]    r_p_clr_i;
  logic [BITS_MTB-1:0]    r_p_mtb;
  logic [BITS_W_ADDR-1:0] r_p_w_addr;

  // Tags follow the read by one cycle so they line up with i_rd_data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p_w_sel  <= '0;
      r_p_clr_i  <= '0;
      r_p_mtb    <= '0;
      r_p_w_addr <= '0;
    end else if (w_rd_en) begin
      r_p_w_sel  <= r_w_sel;
      r_p_clr_i  <= r_clr_i;
      r_p_mtb    <= r_mtb;
      r_p_w_addr <= r_w_addr;
    end
  end

  assign w_push = {r_p_last, r_p_w_sel, r_p_clr_i, r_p_mtb, r_p_w_addr, i_rd_data};
  assign {o_m_last, o_m_w_sel, o_m_clr_i, o_m_mtb, o_m_w_addr, o_m_data} = w_pop;
`else
  assign w_push     = {r_p_last, i_rd_data};
  assign {o_m_last, o_m_data} = w_pop;
  assign o_m_w_sel  = '0;
  assign o_m_clr_i  = '0;
  assign o_m_mtb    = '0;
  assign o_m_w_addr = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight <= 1'b0;
      r_p_last   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      r_done     <= w_last_hs;
      if (w_rd_en) r_p_last <= w_stream_end;
    end
  end

  lrelu_beats_skid #(.W(PAY_W)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (r_inflight),
    .i_data  (w_push),
    .o_valid (o_m_valid),
    .i_ready (i_m_ready),
    .o_data  (w_pop),
    .o_count (w_count)
  );

  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = r_done;
  assign o_rd_en   = w_rd_en;
  assign o_rd_addr = r_rd_addr;

endmodule

// File: tb/tb_lrelu_beats_sender.sv
// Directed scoreboard bench for lrelu_beats_sender; tag expectations follow LRELU_SENDER_TAGS_EN.
module tb_lrelu_beats_sender;

`ifdef LRELU_SENDER_TAGS_EN
  localparam bit TAGS = 1'b1;
`else
  localparam bit TAGS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, busy, done, rd_en;
  logic [2:0]   kw2;
  logic [15:0]  n_groups, rd_addr;
  logic [127:0] rd_data, m_data;
  logic         m_valid, m_ready, m_last;
  logic [1:0]   m_w_sel;
  logic [2:0]   m_clr_i, m_w_addr;
  logic [3:0]   m_mtb;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic [1:0]   ws;
    logic [2:0]   c;
    logic [3:0]   m;
    logic [2:0]   a;
  } beat_t;

  beat_t       sb[$];
  int          total = 0;
  int          bad = 0;
  int          issued, accepted;
  logic [15:0] push_addr, exp_addr;

  always #5 clk = ~clk;

  lrelu_beats_sender dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_kw2      (kw2),
    .i_n_groups (n_groups),
    .o_busy     (busy),
    .o_done     (done),
    .o_rd_en    (rd_en),
    .o_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .o_m_valid  (m_valid),
    .i_m_ready  (m_ready),
    .o_m_data   (m_data),
    .o_m_last   (m_last),
    .o_m_w_sel  (m_w_sel),
    .o_m_clr_i  (m_clr_i),
    .o_m_mtb    (m_mtb),
    .o_m_w_addr (m_w_addr)
  );

  function automatic logic [127:0] ram_word(input logic [15:0] a);
    logic [127:0] r;
    for (int i = 0; i < 8; i++)
      r[i*16 +: 16] = (a * 16'd7) ^ (16'h1111 * 16'(i + 1)) ^ 16'h3C5A;
    return r;
  endfunction

  always @(posedge clk) rd_data <= rd_en ? ram_word(rd_addr) : {8{16'hDEAD}};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [1:0] ws, input int c, input int m, input int a);
    beat_t b;
    b.data = ram_word(push_addr);
    b.last = 1'b0;
    b.ws   = ws;
    b.c    = 3'(c);
    b.m    = 4'(m);
    b.a    = 3'(a);
    push_addr++;
    sb.push_back(b);
  endtask

  task automatic push_expected(input int k, input int ng);
    int kk = (k > 5) ? 5 : k;
    int gn = (ng == 0) ? 1 : ng;
    for (int g = 0; g < gn; g++) begin
      push_beat(2'd1, 0, 0, 0);
      for (int a = 0; a <= kk; a++) push_beat(2'd2, 0, 0, a);
      for (int c = 0; c <= kk; c++)
        for (int m = 0; m <= 2 * c; m++)
          for (int a = 0; a < (kk + c + 2) / 2; a++) push_beat(2'd3, c, m, a);
    end
    sb[sb.size() - 1].last = 1'b1;
  endtask

  task automatic do_start(input int k, input int ng);
    @(negedge clk);
    kw2       = 3'(k);
    n_groups  = 16'(ng);
    start     = 1'b1;
    push_addr = '0;
    exp_addr  = '0;
    issued    = 0;
    accepted  = 0;
    push_expected(k, ng);
  endtask

  task automatic run_stream(input int rdy_pct, input int inj_cyc, input int rst_at, input int budget);
    int    cyc = 0;
    bit    fin = 1'b0;
    beat_t b;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inj_cyc);
      if (start) kw2 = 3'd0;
      m_ready = ($urandom_range(99) < rdy_pct);
      if (cyc == 1) begin
        check("busy_t1", busy, 1);
        check("rden_t1", rd_en, 1);
        check("valid_t1", m_valid, 0);
      end
      if (cyc == 2) check("valid_t2", m_valid, 1);
      check("done_low", done, 0);
      if (rd_en) begin
        check("rd_addr", rd_addr, exp_addr);
        exp_addr++;
        issued++;
        check("outstanding", (issued - accepted <= 2), 1);
      end
      if (m_valid) begin
        if (sb.size() == 0) begin
          check("extra_beat", m_valid, 0);
          fin = 1'b1;
        end else begin
          b = sb[0];
          check("data", m_data, b.data);
          check("last", m_last, b.last);
          check("w_sel", m_w_sel, TAGS ? b.ws : 2'd0);
          check("clr_i", m_clr_i, TAGS ? b.c : 3'd0);
          check("mtb", m_mtb, TAGS ? b.m : 4'd0);
          check("w_addr", m_w_addr, TAGS ? b.a : 3'd0);
          if (m_ready) begin
            void'(sb.pop_front());
            accepted++;
            if (sb.size() == 0) fin = 1'b1;
            if (rst_at != 0 && accepted == rst_at) begin
              rst = 1'b1;
              fin = 1'b1;
            end
          end
        end
      end
    end
    if (!fin) check("timeout_beats_left", sb.size(), 0);
    start = 1'b0;
    if (rst_at != 0) begin
      @(negedge clk);
      check("rst_valid", m_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rden", rd_en, 0);
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check("rst_no_done", done, 0);
    end else begin
      @(negedge clk);
      check("done_pulse", done, 1);
      check("busy_after", busy, 0);
      check("valid_after", m_valid, 0);
      @(negedge clk);
      check("done_once", done, 0);
      check("idle_valid", m_valid, 0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    kw2      = 3'd0;
    n_groups = 16'd1;
    m_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_rden0", rd_en, 0);
    check("rst_valid0", m_valid, 0);
    check("rst_last0", m_last, 0);
    check("rst_addr0", rd_addr, 0);
    check("rst_data0", m_data, 0);
    check("rst_tags0", {m_w_sel, m_clr_i, m_mtb, m_w_addr}, 0);
    rst = 1'b0;

    do_start(0, 1);  run_stream(100, 0, 0, 40);
    do_start(1, 2);  run_stream(100, 0, 0, 80);
    do_start(1, 1);  run_stream(50, 0, 0, 200);
    do_start(1, 1);  run_stream(100, 4, 0, 60);
    repeat (3) begin
      @(negedge clk);
      check("ignored_start_valid", m_valid, 0);
      check("ignored_start_busy", busy, 0);
    end
    do_start(1, 1);  run_stream(100, 0, 5, 60);
    do_start(1, 1);  run_stream(100, 0, 0, 60);
    do_start(7, 0);  run_stream(70, 0, 0, 800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
